// File: rtl/cello_gate_pkg.sv
// Shared types for the 3-input gate front end:
// gate input vector, settle FSM states, settle limits.
package cello_gate_pkg;

   typedef logic [2:0] gate_in_t;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESENT      = 2'd1,
      PRESENT_PEND = 2'd2
   } settle_state_e;

   localparam int SETTLE_CYCLES_MIN = 2;

endpackage

// File: rtl/inducer_sync.sv
// Per-bit 2-flop synchronizer for asynchronous inducer lines.
// Used only when INDUCER_SYNC_EN is defined.
module inducer_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/inducer_settle3.sv
// Settle filter + valid/ready publisher for the 3 inducer lines.
// Define INDUCER_SYNC_EN to add a 2-flop input synchronizer.
module inducer_settle3
   import cello_gate_pkg::*;
#(
   parameter int STABLE_CYCLES = 8,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] in_raw,
   output logic [2:0] out_vec,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overrun
);

   gate_in_t      s;
   gate_in_t      cand_q, cand_d;
   gate_in_t      vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   settle_state_e state_q, state_d;
   logic          ovr_q, ovr_d;
   logic          sat;

`ifdef INDUCER_SYNC_EN
   inducer_sync #(
      .W(3)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (in_raw),
      .q_o  (s)
   );
`else
   assign s = in_raw;
`endif

   assign sat = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q  <= '0;
         cnt_q   <= '0;
         vec_q   <= '0;
         state_q <= IDLE;
         ovr_q   <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         state_q <= state_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      state_d = state_q;
      ovr_d   = 1'b0;
      if (s != cand_q) begin
         cand_d = s;
         cnt_d  = '0;
         if (state_q == PRESENT_PEND) begin
            ovr_d   = 1'b1;
            state_d = PRESENT;
         end
      end else if (!sat) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (cand_q != vec_q) begin
         unique case (state_q)
            IDLE: begin
               vec_d   = cand_q;
               state_d = PRESENT;
            end
            PRESENT: state_d = PRESENT_PEND;
            default: ;
         endcase
      end
      // accept wins over a same-edge stable candidate
      if (state_q != IDLE && out_ready) begin
         state_d = IDLE;
      end
   end

   assign out_vec   = vec_q;
   assign out_valid = (state_q != IDLE);
   assign overrun   = ovr_q;

endmodule
